// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone master arbiter: FSM states, owner index type
// and a width helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_MASTERS = 8;

    typedef logic [$clog2(MAX_MASTERS)-1:0] owner_idx_t;

    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bundles the master-side and slave-side Wishbone B4 pipelined signals that
// pass through the arbiter.
interface wb_master_arbiter_if #(
  parameter int unsigned NrMasters = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NrMasters-1:0]                   m_cyc;
  logic [NrMasters-1:0]                   m_stb;
  logic [NrMasters-1:0]                   m_we;
  logic [NrMasters-1:0][AddrWidth-1:0]    m_adr;
  logic [NrMasters-1:0][DataWidth/8-1:0]  m_sel;
  logic [NrMasters-1:0][DataWidth-1:0]    m_dat;
  logic [DataWidth-1:0]                   m_rdat;
  logic [NrMasters-1:0]                   m_ack;
  logic [NrMasters-1:0]                   m_err;
  logic [NrMasters-1:0]                   m_stall;
  logic                                   s_cyc;
  logic                                   s_stb;
  logic                                   s_we;
  logic [AddrWidth-1:0]                   s_adr;
  logic [DataWidth/8-1:0]                 s_sel;
  logic [DataWidth-1:0]                   s_dat;
  logic [DataWidth-1:0]                   s_rdat;
  logic                                   s_ack;
  logic                                   s_err;
  logic                                   s_stall;

  modport arbiter (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat,
    output m_rdat, m_ack, m_err, m_stall,
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat,
    input  s_rdat, s_ack, s_err, s_stall
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat,
    input  m_rdat, m_ack, m_err, m_stall
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat,
    output s_rdat, s_ack, s_err, s_stall
  );
endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, with an
// optional strict-priority override for requester 0.
module wb_arb_rr_pick #(
  parameter int unsigned NrMasters = 3,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic [NrMasters-1:0] req,
  input  logic [IdxWidth-1:0]  last,
  input  logic                 prio0,
  output logic [IdxWidth-1:0]  grant,
  output logic                 valid
);
  logic [IdxWidth-1:0] rr_grant_s;
  logic                rr_valid_s;
  int unsigned         idx_s;

  // Scan from farthest to nearest so the requester closest after last is kept.
  always_comb begin
    rr_grant_s = '0;
    rr_valid_s = 1'b0;
    idx_s      = 0;
    for (int unsigned k = NrMasters; k > 0; k--) begin
      idx_s = (32'(last) + k) % NrMasters;
      if (req[idx_s[IdxWidth-1:0]]) begin
        rr_grant_s = idx_s[IdxWidth-1:0];
        rr_valid_s = 1'b1;
      end else begin
        rr_grant_s = rr_grant_s;
      end
    end
  end

  // Apply the priority override on top of the rotating choice.
  always_comb begin
    if (prio0 && req[0]) begin
      grant = '0;
      valid = 1'b1;
    end else begin
      grant = rr_grant_s;
      valid = rr_valid_s;
    end
  end
endmodule

// File: rtl/wb_master_arbiter_chk.sv
// Protocol invariants of the arbiter: single responder, quiet slave port when
// idle, bounded pipeline depth.
module wb_master_arbiter_chk #(
  parameter int unsigned        NrMasters = 3,
  parameter int unsigned        CntWidth  = 3,
  parameter logic [CntWidth-1:0] MaxCnt   = '0
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NrMasters-1:0] m_ack,
  input logic [NrMasters-1:0] m_err,
  input logic                 s_cyc,
  input logic                 idle,
  input logic [CntWidth-1:0]  outstanding
);
  a_resp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_ack | m_err));
  a_idle_no_cyc: assert property (@(posedge clk) disable iff (rst) idle |-> !s_cyc);
  a_out_bound:   assert property (@(posedge clk) disable iff (rst) outstanding <= MaxCnt);
endmodule

// File: rtl/wb_master_arbiter.sv
// Shares one Wishbone B4 pipelined slave among NrMasters masters with
// round-robin arbitration, outstanding-strobe cap and a hang watchdog.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NrMasters      = 3,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter int unsigned DbgPriority    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  wb_master_arbiter_if.arbiter         bus,
  output logic [$clog2(NrMasters)-1:0] owner,
  output logic                         busy
);
  localparam int unsigned     OW         = $clog2(NrMasters);
  localparam int unsigned     CW         = $clog2(MaxOutstanding + 1);
  localparam int unsigned     WW         = min1_clog2(TimeoutCycles);
  localparam logic [CW-1:0]   OUT_MAX    = CW'(MaxOutstanding);
  localparam logic [WW-1:0]   WDOG_LIMIT = WW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);
  localparam logic            WDOG_EN    = 1'(TimeoutCycles != 0);
  localparam logic            PRIO0      = 1'(DbgPriority != 0);

  arb_state_e    state_r;
  logic [OW-1:0] owner_r;
  logic [OW-1:0] last_r;
  logic [CW-1:0] out_r;
  logic [WW-1:0] wdog_r;
  logic          err_pend_r;

  logic [OW-1:0] grant_s;
  logic          grant_vld_s;
  logic          cap_s;
  logic          own_cyc_s;
  logic          accept_s;
  logic          resp_s;
  logic          wdog_hit_s;
  logic [CW-1:0] out_next_s;

  wb_arb_rr_pick #(.NrMasters(NrMasters), .IdxWidth(OW)) u_pick (
    .req   (bus.m_cyc),
    .last  (last_r),
    .prio0 (PRIO0),
    .grant (grant_s),
    .valid (grant_vld_s)
  );

  assign bus.m_rdat = bus.s_rdat;
  assign owner      = owner_r;
  assign busy       = (state_r != IDLE);

  // Owner-to-slave routing; outside BUSY the slave sees no cycle and every master is stalled.
  always_comb begin
    cap_s       = (out_r == OUT_MAX);
    own_cyc_s   = bus.m_cyc[owner_r];
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = bus.m_we[owner_r];
    bus.s_adr   = bus.m_adr[owner_r];
    bus.s_sel   = bus.m_sel[owner_r];
    bus.s_dat   = bus.m_dat[owner_r];
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_stall = '1;
    if (state_r == BUSY) begin
      bus.s_cyc              = own_cyc_s;
      bus.s_stb              = bus.m_stb[owner_r] & ~cap_s;
      bus.m_stall[owner_r]   = bus.s_stall | cap_s;
      bus.m_ack[owner_r]     = bus.s_ack;
      bus.m_err[owner_r]     = bus.s_err;
    end else if (state_r == ABORT) begin
      bus.m_err[owner_r]     = err_pend_r;
    end else begin
      bus.s_cyc              = 1'b0;
    end
  end

  // Pipeline depth bookkeeping and watchdog trigger for the current tenure.
  always_comb begin
    accept_s   = (state_r == BUSY) & bus.s_stb & ~bus.s_stall;
    resp_s     = (state_r == BUSY) & (bus.s_ack | bus.s_err);
    wdog_hit_s = WDOG_EN & (out_r != '0) & ~resp_s & (wdog_r == WDOG_LIMIT);
    if (accept_s && !resp_s) begin
      out_next_s = out_r + CW'(1);
    end else if (!accept_s && resp_s && (out_r != '0)) begin
      out_next_s = out_r - CW'(1);
    end else begin
      out_next_s = out_r;
    end
  end

  // Tenure FSM: a dropped owner cycle always takes precedence over a watchdog abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      last_r     <= OW'(NrMasters - 1);
      out_r      <= '0;
      wdog_r     <= '0;
      err_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_r      <= '0;
          wdog_r     <= '0;
          err_pend_r <= 1'b0;
          if (grant_vld_s) begin
            owner_r <= grant_s;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc_s) begin
            state_r <= IDLE;
            last_r  <= owner_r;
            out_r   <= '0;
            wdog_r  <= '0;
          end else if (wdog_hit_s) begin
            state_r    <= ABORT;
            err_pend_r <= 1'b1;
            out_r      <= '0;
            wdog_r     <= '0;
          end else begin
            out_r  <= out_next_s;
            wdog_r <= ((out_r != '0) && !resp_s) ? wdog_r + WW'(1) : '0;
          end
        end
        ABORT: begin
          err_pend_r <= 1'b0;
          if (!own_cyc_s) begin
            state_r <= IDLE;
            last_r  <= owner_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  wb_master_arbiter_chk #(.NrMasters(NrMasters), .CntWidth(CW), .MaxCnt(OUT_MAX)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .m_ack       (bus.m_ack),
    .m_err       (bus.m_err),
    .s_cyc       (bus.s_cyc),
    .idle        (state_r == IDLE),
    .outstanding (out_r)
  );
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios plus random
// tenures checked against a rule-level arbitration model.
module tb_wb_master_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] owner;
  logic       busy;
  int         checks     = 0;
  int         failures   = 0;
  int         model_last = 2;

  wb_master_arbiter_if #(.NrMasters(3), .AddrWidth(32), .DataWidth(32)) bus ();

  wb_master_arbiter #(
    .NrMasters(3), .AddrWidth(32), .DataWidth(32),
    .MaxOutstanding(4), .TimeoutCycles(16), .DbgPriority(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master 0 has strict priority; otherwise the first requester after last, wrapping.
  function automatic int model_pick(input logic [2:0] mask, input int last);
    if (mask[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (mask[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0; bus.m_adr = '0; bus.m_sel = '0; bus.m_dat = '0;
    bus.s_rdat = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_stall = 1'b0;
  endtask

  task automatic start_tenure(input logic [2:0] mask, output int own);
    bus.m_cyc = mask;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.s_cyc !== 1'b0) begin
      failures++; $display("FAIL idle_before_grant: busy=%0b s_cyc=%0b, want 0/0", busy, bus.s_cyc);
    end
    tick();
    own = model_pick(mask, model_last);
    checks++;
    if (busy !== 1'b1 || owner !== own[1:0] || bus.s_cyc !== 1'b1) begin
      failures++;
      $display("FAIL grant: busy=%0b owner=%0d s_cyc=%0b, want 1/%0d/1 (mask=%b last=%0d)", busy, owner, bus.s_cyc, own, mask, model_last);
    end
  endtask

  task automatic end_tenure(input int own);
    bus.m_cyc[own[1:0]] = 1'b0;
    bus.m_stb = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || bus.s_cyc !== 1'b0 || bus.m_stall !== 3'b111) begin
      failures++; $display("FAIL release: busy=%0b s_cyc=%0b stall=%b, want 0/0/111", busy, bus.s_cyc, bus.m_stall);
    end
    model_last = own;
  endtask

  task automatic xfer(input int own, input logic [31:0] a, input logic we, input int lat, input bit use_err);
    logic [31:0] d, r;
    logic [3:0]  sel;
    logic [2:0]  oh;
    oh  = 3'b001 << own;
    d   = $urandom;
    sel = 4'($urandom_range(0, 15));
    for (int j = 0; j < 3; j++) begin
      bus.m_stb[j] = 1'($urandom_range(0, 1));
      bus.m_adr[j] = $urandom;
      bus.m_we[j]  = 1'($urandom_range(0, 1));
    end
    bus.m_stb[own[1:0]] = 1'b1; bus.m_we[own[1:0]] = we; bus.m_adr[own[1:0]] = a;
    bus.m_sel[own[1:0]] = sel;  bus.m_dat[own[1:0]] = d;
    #1;
    checks++;
    if (bus.s_stb !== 1'b1 || bus.s_adr !== a || bus.s_we !== we || bus.s_sel !== sel || bus.s_dat !== d) begin
      failures++;
      $display("FAIL xfer_forward: stb=%0b adr=%h we=%0b sel=%h dat=%h, want 1/%h/%0b/%h/%h", bus.s_stb, bus.s_adr, bus.s_we, bus.s_sel, bus.s_dat, a, we, sel, d);
    end
    checks++;
    if (bus.m_stall !== ~oh) begin
      failures++; $display("FAIL xfer_stall: m_stall=%b, want %b", bus.m_stall, ~oh);
    end
    tick();
    bus.m_stb = '0;
    for (int w = 0; w < lat; w++) begin
      checks++;
      if (bus.m_ack !== 3'b000 || bus.m_err !== 3'b000) begin
        failures++; $display("FAIL xfer_early_resp: ack=%b err=%b, want 000/000", bus.m_ack, bus.m_err);
      end
      tick();
    end
    r = $urandom;
    bus.s_rdat = r;
    if (use_err) bus.s_err = 1'b1;
    else         bus.s_ack = 1'b1;
    #1;
    checks++;
    if (bus.m_ack !== (use_err ? 3'b000 : oh) || bus.m_err !== (use_err ? oh : 3'b000) || bus.m_rdat !== r) begin
      failures++;
      $display("FAIL xfer_resp: ack=%b err=%b rdat=%h, want %b/%b/%h", bus.m_ack, bus.m_err, bus.m_rdat, use_err ? 3'b000 : oh, use_err ? oh : 3'b000, r);
    end
    tick();
    bus.s_ack = 1'b0;
    bus.s_err = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || owner !== 2'd0 || bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: busy=%0b owner=%0d s_cyc=%0b s_stb=%0b, want 0/0/0/0", busy, owner, bus.s_cyc, bus.s_stb);
    end
    checks++;
    if (bus.m_ack !== 3'b000 || bus.m_err !== 3'b000 || bus.m_stall !== 3'b111) begin
      failures++; $display("FAIL reset_resp: ack=%b err=%b stall=%b, want 000/000/111", bus.m_ack, bus.m_err, bus.m_stall);
    end
    rst = 1'b0;
    model_last = 2;
  endtask

  task automatic test_round_robin();
    int own;
    for (int i = 0; i < 4; i++) begin
      start_tenure(3'b110, own);
      repeat (2) tick();
      end_tenure(own);
    end
    bus.m_cyc = '0;
  endtask

  task automatic test_single();
    int own;
    start_tenure(3'b010, own);
    xfer(own, 32'h0000_0100, 1'b0, 2, 1'b0);
    end_tenure(own);
  endtask

  task automatic test_dbg_priority();
    int own;
    start_tenure(3'b100, own);
    bus.m_cyc = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || owner !== 2'd2) begin
        failures++; $display("FAIL no_preempt: busy=%0b owner=%0d, want 1/2", busy, owner);
      end
    end
    end_tenure(2);
    start_tenure(3'b011, own);
    end_tenure(own);
    start_tenure(3'b010, own);
    end_tenure(own);
  endtask

  task automatic test_cap();
    int own;
    start_tenure(3'b010, own);
    bus.m_stb[1] = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.s_stb !== 1'b1 || bus.m_stall[1] !== 1'b0) begin
        failures++; $display("FAIL cap_accept%0d: s_stb=%0b stall=%0b, want 1/0", k, bus.s_stb, bus.m_stall[1]);
      end
      tick();
    end
    bus.s_ack = 1'b1;
    #1;
    checks++;
    if (bus.s_stb !== 1'b0 || bus.m_stall[1] !== 1'b1 || bus.m_ack !== 3'b010) begin
      failures++; $display("FAIL cap_full: s_stb=%0b stall=%0b ack=%b, want 0/1/010", bus.s_stb, bus.m_stall[1], bus.m_ack);
    end
    tick();
    bus.s_ack = 1'b0;
    #1;
    checks++;
    if (bus.s_stb !== 1'b1 || bus.m_stall[1] !== 1'b0) begin
      failures++; $display("FAIL cap_fifth: s_stb=%0b stall=%0b, want 1/0", bus.s_stb, bus.m_stall[1]);
    end
    tick();
    checks++;
    if (bus.s_stb !== 1'b0 || bus.m_stall[1] !== 1'b1) begin
      failures++; $display("FAIL cap_refull: s_stb=%0b stall=%0b, want 0/1", bus.s_stb, bus.m_stall[1]);
    end
    end_tenure(own);
  endtask

  task automatic test_timeout();
    int own;
    start_tenure(3'b100, own);
    bus.m_stb[2] = 1'b1;
    tick();
    bus.m_stb = '0;
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (busy !== 1'b1 || bus.s_cyc !== 1'b1 || bus.m_err !== 3'b000) begin
        failures++; $display("FAIL wdog_wait%0d: busy=%0b s_cyc=%0b err=%b, want 1/1/000", i, busy, bus.s_cyc, bus.m_err);
      end
      tick();
    end
    bus.s_ack = 1'b1;
    #1;
    checks++;
    if (bus.s_cyc !== 1'b0 || bus.m_err !== 3'b100 || bus.m_stall !== 3'b111 || bus.m_ack !== 3'b000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_entry: s_cyc=%0b err=%b stall=%b ack=%b busy=%0b, want 0/100/111/000/1", bus.s_cyc, bus.m_err, bus.m_stall, bus.m_ack, busy);
    end
    tick();
    bus.s_ack = 1'b0;
    #1;
    checks++;
    if (bus.s_cyc !== 1'b0 || bus.m_err !== 3'b000 || busy !== 1'b1) begin
      failures++; $display("FAIL abort_hold: s_cyc=%0b err=%b busy=%0b, want 0/000/1", bus.s_cyc, bus.m_err, busy);
    end
    end_tenure(own);
  endtask

  task automatic test_random();
    int own;
    logic [2:0] mask;
    for (int t = 0; t < 12; t++) begin
      mask = 3'($urandom_range(1, 7));
      start_tenure(mask, own);
      for (int n = $urandom_range(1, 3); n > 0; n--) begin
        xfer(own, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      end
      end_tenure(own);
    end
    bus.m_cyc = '0;
  endtask

  task automatic test_reset_mid();
    int own;
    start_tenure(3'b010, own);
    bus.m_stb[1] = 1'b1;
    repeat (2) tick();
    bus.m_stb = '0;
    bus.m_cyc = 3'b111;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.s_cyc !== 1'b0 || bus.m_stall !== 3'b111 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++; $display("FAIL reset_mid: s_cyc=%0b stall=%b busy=%0b owner=%0d, want 0/111/0/0", bus.s_cyc, bus.m_stall, busy, owner);
    end
    tick();
    rst = 1'b0;
    model_last = 2;
    start_tenure(3'b111, own);
    end_tenure(own);
    bus.m_cyc = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench still running at 200000, want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_dbg_priority();
    test_cap();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
